// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: memory op codes, exception codes, reset constants.
// Latency: n/a (types, constants and pure combinational helpers only).
// Backpressure: n/a.
package mem_access_stage_pkg;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LB   = 4'd1,
      OP_LBU  = 4'd2,
      OP_LH   = 4'd3,
      OP_LHU  = 4'd4,
      OP_LW   = 4'd5,
      OP_SB   = 4'd6,
      OP_SH   = 4'd7,
      OP_SW   = 4'd8
   } mem_op_t;

   localparam logic [1:0] EXCP_NONE     = 2'd0;
   localparam logic [1:0] EXCP_MISALIGN = 2'd1;
   localparam logic [1:0] EXCP_TIMEOUT  = 2'd2;

   localparam logic RstEnable  = 1'b1;
   localparam int   NOPRegAddr = 0;
   localparam int   ZeroWord   = 0;

   function automatic logic is_load(input logic [3:0] op);
      return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   // Halves need an even address, words need a 4-byte aligned address.
   function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
      logic r;
      r = 1'b0;
      case (op)
         OP_LH, OP_LHU, OP_SH: r = a[0];
         OP_LW, OP_SW:         r = |a;
         default:              r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores (data replication + byte enables) and load extract/extend.
// Latency: purely combinational.
// Backpressure: none; follows whatever op/offset the caller presents.
module mem_lane_align
   import mem_access_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [3:0]                    op,
   input  logic [$clog2(DATA_W/8)-1:0]   off,
   input  logic [DATA_W-1:0]             sdata,
   input  logic [DATA_W-1:0]             rdata,
   output logic [DATA_W/8-1:0]           be,
   output logic [DATA_W-1:0]             wdata,
   output logic [DATA_W-1:0]             ldata
);

   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0] shifted;

   // Shift the addressed lane down to bit 0, then pick width/extension per op.
   always_comb begin
      be      = '0;
      wdata   = '0;
      ldata   = '0;
      shifted = rdata >> {off, 3'b000};
      case (op)
         OP_LB, OP_LBU, OP_SB: be = NB'(1) << off;
         OP_LH, OP_LHU, OP_SH: be = NB'(3) << off;
         OP_LW, OP_SW:         be = '1;
         default:              be = '0;
      endcase
      case (op)
         OP_SB:   wdata = {NB{sdata[7:0]}};
         OP_SH:   wdata = {(NB/2){sdata[15:0]}};
         OP_SW:   wdata = sdata;
         OP_LB:   ldata = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
         OP_LBU:  ldata = {{(DATA_W-8){1'b0}}, shifted[7:0]};
         OP_LH:   ldata = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
         OP_LHU:  ldata = {{(DATA_W-16){1'b0}}, shifted[15:0]};
         OP_LW:   ldata = rdata;
         default: ldata = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: forwards ALU results, runs loads/stores over a req/ack bus, registers WB.
// Latency: 1 cycle for ALU ops; memory ops complete on the edge after dm_ack_i.
// Backpressure: stall_o holds EX/MEM while a request waits for ack; dropped in ack/timeout cycle.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int TIMEOUT    = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid_i,
   input  logic [3:0]              op_i,
   input  logic [REG_ADDR_W-1:0]   wd_i,
   input  logic                    wreg_i,
   input  logic [DATA_W-1:0]       wdata_i,
   input  logic [ADDR_W-1:0]       addr_i,
   input  logic [DATA_W-1:0]       sdata_i,
   input  logic                    flush_i,
   output logic                    stall_o,
   output logic                    dm_req_o,
   output logic                    dm_we_o,
   output logic [ADDR_W-1:0]       dm_addr_o,
   output logic [DATA_W/8-1:0]     dm_be_o,
   output logic [DATA_W-1:0]       dm_wdata_o,
   input  logic [DATA_W-1:0]       dm_rdata_i,
   input  logic                    dm_ack_i,
   output logic [REG_ADDR_W-1:0]   wd_o,
   output logic                    wreg_o,
   output logic [DATA_W-1:0]       wdata_o,
   output logic [1:0]              excp_o,
   output logic [ADDR_W-1:0]       badaddr_o
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACCESS = 1'b1;

   logic [0:0]            state_q;
   logic [3:0]            op_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [DATA_W-1:0]     sdata_q;
   logic [REG_ADDR_W-1:0] wd_q;
   logic                  wreg_q;
   logic                  flushed_q;
   logic [CNT_W-1:0]      cnt_q;

   logic                  in_access;
   logic                  mis;
   logic                  start;
   logic                  timeout;
   logic                  discard;
   logic [3:0]            op_s;
   logic [ADDR_W-1:0]     addr_s;
   logic [DATA_W-1:0]     sdata_s;
   logic [NB-1:0]         be_s;
   logic [DATA_W-1:0]     wdata_s;
   logic [DATA_W-1:0]     ldata;

   // While waiting, the bus is driven from the captured copy so it stays stable until ack.
   assign in_access = (state_q == ACCESS);
   assign op_s      = in_access ? op_q    : op_i;
   assign addr_s    = in_access ? addr_q  : addr_i;
   assign sdata_s   = in_access ? sdata_q : sdata_i;

   assign mis     = !in_access && valid_i && !flush_i && misaligned(op_i, addr_i[1:0]);
   assign start   = !in_access && valid_i && !flush_i && (is_load(op_i) || is_store(op_i)) && !mis;
   assign timeout = in_access && !dm_ack_i && (cnt_q == CNT_W'(TIMEOUT - 1));
   assign discard = flushed_q || flush_i;

   assign dm_req_o   = in_access || start;
   assign dm_we_o    = dm_req_o && is_store(op_s);
   assign dm_addr_o  = dm_req_o ? {addr_s[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
   assign dm_be_o    = dm_req_o ? be_s : '0;
   assign dm_wdata_o = dm_req_o ? wdata_s : '0;
   // The timeout cycle releases the stall so upstream advances exactly once.
   assign stall_o    = dm_req_o && !dm_ack_i && !timeout;

   mem_lane_align #(.DATA_W(DATA_W)) u_align (
      .op    (op_s),
      .off   (addr_s[OFF_W-1:0]),
      .sdata (sdata_s),
      .rdata (dm_rdata_i),
      .be    (be_s),
      .wdata (wdata_s),
      .ldata (ldata)
   );

   // FSM, request capture and wait counter.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_q   <= IDLE;
         op_q      <= '0;
         addr_q    <= '0;
         sdata_q   <= '0;
         wd_q      <= '0;
         wreg_q    <= 1'b0;
         flushed_q <= 1'b0;
         cnt_q     <= '0;
      end else if (!in_access) begin
         if (start && !dm_ack_i) begin
            state_q   <= ACCESS;
            op_q      <= op_i;
            addr_q    <= addr_i;
            sdata_q   <= sdata_i;
            wd_q      <= wd_i;
            wreg_q    <= wreg_i;
            flushed_q <= 1'b0;
            cnt_q     <= '0;
         end
      end else if (dm_ack_i || timeout) begin
         state_q <= IDLE;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
         if (flush_i) flushed_q <= 1'b1;
      end
   end

   // Writeback registers and one-cycle exception pulse.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         wd_o      <= REG_ADDR_W'(NOPRegAddr);
         wreg_o    <= 1'b0;
         wdata_o   <= DATA_W'(ZeroWord);
         excp_o    <= EXCP_NONE;
         badaddr_o <= '0;
      end else begin
         wreg_o    <= 1'b0;
         excp_o    <= EXCP_NONE;
         badaddr_o <= '0;
         if (in_access) begin
            if (dm_ack_i) begin
               wd_o    <= wd_q;
               wdata_o <= ldata;
               wreg_o  <= wreg_q && is_load(op_q) && !discard;
            end else if (timeout && !discard) begin
               excp_o    <= EXCP_TIMEOUT;
               badaddr_o <= addr_q;
            end
         end else if (valid_i && !flush_i) begin
            if (mis) begin
               excp_o    <= EXCP_MISALIGN;
               badaddr_o <= addr_i;
            end else if (!start) begin
               wd_o    <= wd_i;
               wreg_o  <= wreg_i;
               wdata_o <= wdata_i;
            end else if (dm_ack_i) begin
               wd_o    <= wd_i;
               wdata_o <= ldata;
               wreg_o  <= wreg_i && is_load(op_i);
            end
         end
      end
   end

endmodule
